mem_ctrl: RTL

//  Responder side of the ram_bus load protocol and the committed-store port: serialises
//  32-bit load/store requests onto the byte-wide RAM (1-cycle read latency).

---
 rtl/mem_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder for ram_bus loads and committed stores, serialised onto a byte-wide RAM.
//
// The RAM has a one-cycle read latency: the address driven after edge j is returned on
// mem_din_in and captured at edge j+1. Multi-byte accesses are little endian, byte i at A+i.
//
// Access type encoding (ram_bus_inst_type_in / st_inst_type_in):
//   [1:0] size: 0 = byte, 1 = half, 2 = word
//   [2]   1 = zero-extend (LBU/LHU); ignored for stores
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global enable; low freezes all state and outputs
//   rob_flush_in            mispredict flush; aborts an in-flight load only
//   ram_bus_*_in            load request (valid, address, ROB tag, type)
//   ram_bus_rdy_out         load request may be accepted (combinational)
//   ram_bus_data_en_out     one-cycle load result strobe with data and ROB tag
//   st_*_in                 committed store request (valid, address, data, type)
//   st_done_out             one-cycle store completion strobe
//   mem_din_in              RAM read byte
//   mem_dout_out            RAM write byte
//   mem_a_out, mem_wr_out   RAM byte address and write enable
module mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ROB_W      = 4,
    parameter int unsigned TYPE_W     = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_flush_in,

    input  logic                  ram_bus_en_in,
    input  logic [ADDR_WIDTH-1:0] ram_bus_A_in,
    input  logic [ROB_W-1:0]      ram_bus_dest_in,
    input  logic [TYPE_W-1:0]     ram_bus_inst_type_in,
    output logic                  ram_bus_rdy_out,
    output logic                  ram_bus_data_en_out,
    output logic [DATA_WIDTH-1:0] ram_bus_data_out,
    output logic [ROB_W-1:0]      ram_bus_dest_out,

    input  logic                  st_en_in,
    input  logic [ADDR_WIDTH-1:0] st_A_in,
    input  logic [DATA_WIDTH-1:0] st_data_in,
    input  logic [TYPE_W-1:0]     st_inst_type_in,
    output logic                  st_done_out,

    input  logic [7:0]            mem_din_in,
    output logic [7:0]            mem_dout_out,
    output logic [ADDR_WIDTH-1:0] mem_a_out,
    output logic                  mem_wr_out
);

    typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

    state_e                state_q;
    logic [2:0]            cnt_q;       // LOAD: bytes captured; STORE: bytes issued
    logic [TYPE_W-1:0]     ld_type_q;
    logic [ROB_W-1:0]      ld_dest_q;
    logic [DATA_WIDTH-1:0] ld_buf_q;
    logic [1:0]            st_size_q;
    logic [DATA_WIDTH-1:0] st_data_q;

    logic [2:0]            ld_n;
    logic [2:0]            st_n;
    logic [DATA_WIDTH-1:0] ld_word;
    logic [DATA_WIDTH-1:0] ld_result;
    logic                  ld_accept;
    logic                  unused_st_type;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [TYPE_W-1:0]     t);
        logic sgn;
        sgn = ~t[2];
        case (t[1:0])
            2'd0:    extend = {{(DATA_WIDTH-8){sgn & w[7]}}, w[7:0]};
            2'd1:    extend = {{(DATA_WIDTH-16){sgn & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    // Stores carry no signedness.
    assign unused_st_type = ^st_inst_type_in[TYPE_W-1:2];

    assign ld_n = size_bytes(ld_type_q[1:0]);
    assign st_n = size_bytes(st_size_q);

    // Final load word includes the byte arriving this cycle, so the result can be
    // registered on the same edge that captures the last byte.
    always_comb begin
        ld_word = ld_buf_q;
        ld_word[8*cnt_q[1:0] +: 8] = mem_din_in;
    end

    assign ld_result = extend(ld_word, ld_type_q);

    assign ram_bus_rdy_out = (state_q == StIdle) && !st_en_in && !rst_in;
    assign ld_accept       = ram_bus_rdy_out && ram_bus_en_in && !rob_flush_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q             <= StIdle;
            cnt_q               <= 3'd0;
            ld_type_q           <= '0;
            ld_dest_q           <= '0;
            ld_buf_q            <= '0;
            st_size_q           <= 2'd0;
            st_data_q           <= '0;
            ram_bus_data_en_out <= 1'b0;
            ram_bus_data_out    <= '0;
            ram_bus_dest_out    <= '0;
            st_done_out         <= 1'b0;
            mem_dout_out        <= 8'd0;
            mem_a_out           <= '0;
            mem_wr_out          <= 1'b0;
        end else if (rdy_in) begin
            ram_bus_data_en_out <= 1'b0;
            st_done_out         <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (st_en_in) begin
                        // Byte 0 goes out immediately; the rest follow one per cycle.
                        state_q      <= StStore;
                        st_size_q    <= st_inst_type_in[1:0];
                        st_data_q    <= st_data_in;
                        mem_wr_out   <= 1'b1;
                        mem_a_out    <= st_A_in;
                        mem_dout_out <= st_data_in[7:0];
                        cnt_q        <= 3'd1;
                    end else if (ld_accept) begin
                        state_q    <= StLoad;
                        ld_type_q  <= ram_bus_inst_type_in;
                        ld_dest_q  <= ram_bus_dest_in;
                        mem_wr_out <= 1'b0;
                        mem_a_out  <= ram_bus_A_in;
                        cnt_q      <= 3'd0;
                    end
                end
                StLoad: begin
                    if (rob_flush_in) begin
                        state_q <= StIdle;
                        cnt_q   <= 3'd0;
                    end else begin
                        ld_buf_q[8*cnt_q[1:0] +: 8] <= mem_din_in;
                        if (cnt_q == ld_n - 3'd1) begin
                            state_q             <= StIdle;
                            cnt_q               <= 3'd0;
                            ram_bus_data_en_out <= 1'b1;
                            ram_bus_data_out    <= ld_result;
                            ram_bus_dest_out    <= ld_dest_q;
                        end else begin
                            mem_a_out <= mem_a_out + ADDR_WIDTH'(1);
                            cnt_q     <= cnt_q + 3'd1;
                        end
                    end
                end
                StStore: begin
                    // Flush is deliberately ignored: committed stores always finish.
                    if (cnt_q == st_n) begin
                        state_q     <= StIdle;
                        cnt_q       <= 3'd0;
                        mem_wr_out  <= 1'b0;
                        st_done_out <= 1'b1;
                    end else begin
                        mem_a_out    <= mem_a_out + ADDR_WIDTH'(1);
                        mem_dout_out <= st_data_q[8*cnt_q[1:0] +: 8];
                        cnt_q        <= cnt_q + 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
